// File: rtl/sprite_animator_if.sv
// Sprite ROM / palette bus between the renderer (master) and its lookup memories (slave).
interface sprite_animator_if #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned IDX_BITS = 4
);
  logic [ADDR_W-1:0]   rom_address;
  logic [IDX_BITS-1:0] rom_q;
  logic [IDX_BITS-1:0] pal_index;
  logic [3:0]          pal_red;
  logic [3:0]          pal_green;
  logic [3:0]          pal_blue;

  modport master (
    output rom_address,
    output pal_index,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  modport slave (
    input  rom_address,
    input  pal_index,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );
endinterface

// File: rtl/sprite_animator.sv
// Animated, integer-scaled sprite over a background colour; 2-cycle coordinate-to-RGB pipeline.
// Position, scale and animation frame change only at frame start, so a frame never tears.
module sprite_animator #(
  parameter int unsigned SPR_W        = 32,
  parameter int unsigned SPR_H        = 32,
  parameter int unsigned FRAMES       = 4,
  parameter int unsigned IDX_BITS     = 4,
  parameter int unsigned TRANSP_IDX   = 0,
  parameter int unsigned FRAME_PERIOD = 8,
  parameter int unsigned ADDR_W       = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int unsigned FIDX_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned CNT_W       = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              pos_wr,
  input  logic              anim_en,
  input  logic              anim_pingpong,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  sprite_animator_if.master rom_bus,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [FIDX_W-1:0] frame_idx
);

  typedef enum logic [1:0] {StHold, StFwd, StRev} anim_state_e;

  anim_state_e       r_state, w_state_nxt;
  logic [FIDX_W-1:0] r_frame, w_frame_nxt, w_frame_cur;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic       r_origin_seen;
  logic       w_at_origin, w_frame_start;
  logic [9:0] r_shd_x, r_shd_y, r_act_x, r_act_y;
  logic [1:0] r_shd_s, r_act_s;
  logic [9:0] w_cmt_x, w_cmt_y, w_act_x, w_act_y;
  logic [1:0] w_cmt_s, w_act_s;

  logic [10:0] w_dx, w_dy;
  logic [9:0]  w_tx, w_ty;
  logic        w_hit;

  logic        r_hit_d, r_blank_d;
  logic [11:0] r_bg_d, w_pix;

  // Edge flag: holding (0,0) for several cycles still yields a single frame-start event.
  assign w_at_origin   = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign w_frame_start = w_at_origin && !r_origin_seen;

  // A pos_wr coincident with frame start writes through to the active copy.
  assign w_cmt_x = pos_wr ? pos_x : r_shd_x;
  assign w_cmt_y = pos_wr ? pos_y : r_shd_y;
  assign w_cmt_s = pos_wr ? scale : r_shd_s;

  // The frame-start pixel itself already uses the newly committed placement and frame.
  assign w_act_x = w_frame_start ? w_cmt_x : r_act_x;
  assign w_act_y = w_frame_start ? w_cmt_y : r_act_y;
  assign w_act_s = w_frame_start ? w_cmt_s : r_act_s;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_origin_seen <= 1'b0;
      r_shd_x       <= '0;
      r_shd_y       <= '0;
      r_shd_s       <= '0;
      r_act_x       <= '0;
      r_act_y       <= '0;
      r_act_s       <= '0;
    end else begin
      r_origin_seen <= w_at_origin;
      if (pos_wr) begin
        r_shd_x <= pos_x;
        r_shd_y <= pos_y;
        r_shd_s <= scale;
      end
      if (w_frame_start) begin
        r_act_x <= w_cmt_x;
        r_act_y <= w_cmt_y;
        r_act_s <= w_cmt_s;
      end
    end
  end

  // Stage 0: bit 10 of the 11-bit difference is the sign, so left/top never wraps.
  assign w_dx  = {1'b0, DrawX} - {1'b0, w_act_x};
  assign w_dy  = {1'b0, DrawY} - {1'b0, w_act_y};
  assign w_tx  = w_dx[9:0] >> w_act_s;
  assign w_ty  = w_dy[9:0] >> w_act_s;
  assign w_hit = !w_dx[10] && !w_dy[10] && (32'(w_tx) < SPR_W) && (32'(w_ty) < SPR_H);

  assign rom_bus.rom_address = (reset_n && w_hit)
      ? ADDR_W'(32'(w_frame_cur) * SPR_W * SPR_H + 32'(w_ty) * SPR_W + 32'(w_tx))
      : '0;

  // Stage 1: align side-band with the ROM's registered output.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_d   <= 1'b0;
      r_blank_d <= 1'b0;
      r_bg_d    <= '0;
    end else begin
      r_hit_d   <= w_hit;
      r_blank_d <= blank;
      r_bg_d    <= {bg_red, bg_green, bg_blue};
    end
  end

  assign rom_bus.pal_index = rom_bus.rom_q;

  always_comb begin
    w_pix = r_bg_d;
    if (!r_blank_d) begin
      w_pix = '0;
    end else if (r_hit_d && (rom_bus.rom_q != IDX_BITS'(TRANSP_IDX))) begin
      w_pix = {rom_bus.pal_red, rom_bus.pal_green, rom_bus.pal_blue};
    end
  end

  // Stage 2: registered colour outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      {red, green, blue} <= '0;
    end else begin
      {red, green, blue} <= w_pix;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StFwd;
      r_frame <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Leaving HOLD consumes that frame start; counting resumes from the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    if (w_frame_start) begin
      if (!anim_en) begin
        w_state_nxt = StHold;
      end else if (r_state == StHold) begin
        w_state_nxt = StFwd;
      end else if (r_cnt != CNT_W'(FRAME_PERIOD - 1)) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt = '0;
        if (FRAMES == 1) begin
          w_state_nxt = StFwd;
          w_frame_nxt = '0;
        end else if ((r_state == StRev) && anim_pingpong) begin
          if (r_frame == '0) begin
            w_state_nxt = StFwd;
            w_frame_nxt = FIDX_W'(1);
          end else begin
            w_frame_nxt = r_frame - FIDX_W'(1);
          end
        end else begin
          // Forward step; REV with ping-pong switched off also lands here.
          w_state_nxt = StFwd;
          if (r_frame == FIDX_W'(FRAMES - 1)) begin
            if (anim_pingpong) begin
              w_state_nxt = StRev;
              w_frame_nxt = FIDX_W'(FRAMES - 2);
            end else begin
              w_frame_nxt = '0;
            end
          end else begin
            w_frame_nxt = r_frame + FIDX_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    frame_idx   = r_frame;
    w_frame_cur = w_frame_start ? w_frame_nxt : r_frame;
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Randomised scoreboard bench for sprite_animator against a texel-level reference model.
module tb_sprite_animator;
  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int FRAMES = 4;
  localparam int PERIOD = 2;
  localparam int ADDR_W = 12;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic       blank = 1'b0, pos_wr = 1'b0, anim_en = 1'b0, anim_pingpong = 1'b0;
  logic [1:0] scale = '0;
  logic [3:0] bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [3:0] red, green, blue;
  logic [1:0] frame_idx;

  sprite_animator_if #(.ADDR_W(ADDR_W), .IDX_BITS(4)) bus ();

  sprite_animator #(.FRAME_PERIOD(PERIOD)) dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .scale         (scale),
    .pos_wr        (pos_wr),
    .anim_en       (anim_en),
    .anim_pingpong (anim_pingpong),
    .bg_red        (bg_red),
    .bg_green      (bg_green),
    .bg_blue       (bg_blue),
    .rom_bus       (bus.master),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .frame_idx     (frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  logic [3:0] rom_mem [4096];
  always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_address];
  assign bus.pal_red   = bus.pal_index ^ 4'h3;
  assign bus.pal_green = bus.pal_index + 4'h1;
  assign bus.pal_blue  = ~bus.pal_index;

  typedef struct {
    int    due;
    int    kind;   // 0 rom_address, 1 rgb, 2 frame_idx
    int    exp;
    string name;
  } chk_t;
  chk_t sbq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // Reference model state
  int m_sx, m_sy, m_ss, m_ax, m_ay, m_as, m_frame, m_run;
  bit m_prev00;
  bit m_en, m_pp;
  int pp_seq [6] = '{0, 1, 2, 3, 2, 1};

  function automatic int pal(input int idx);
    logic [3:0] v, r, g, b;
    v = idx[3:0];
    r = v ^ 4'h3;
    g = v + 4'h1;
    b = ~v;
    return int'({r, g, b});
  endfunction

  task automatic push(input int due, input int kind, input int exp, input string name);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp; c.name = name;
    sbq.push_back(c);
  endtask

  always @(negedge vga_clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        int act;
        case (sbq[i].kind)
          0:       act = int'(bus.rom_address);
          1:       act = int'({red, green, blue});
          default: act = int'(frame_idx);
        endcase
        checks++;
        if (act != sbq[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", sbq[i].name, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step(input int x, input int y, input bit blk, input bit wr,
                      input int px, input int py, input int ps);
    int dx, dy, tx, ty, addr, rgb, bg;
    bit hit, fs;
    @(posedge vga_clk);
    #1;
    bg = int'($urandom_range(0, 4095));
    DrawX = 10'(x); DrawY = 10'(y); blank = blk;
    pos_wr = wr; pos_x = 10'(px); pos_y = 10'(py); scale = 2'(ps);
    anim_en = m_en; anim_pingpong = m_pp;
    bg_red = 4'(bg >> 8); bg_green = 4'(bg >> 4); bg_blue = 4'(bg);
    fs = (x == 0 && y == 0) && !m_prev00;
    m_prev00 = (x == 0 && y == 0);
    if (wr) begin m_sx = px; m_sy = py; m_ss = ps; end
    if (fs) begin
      m_ax = m_sx; m_ay = m_sy; m_as = m_ss;
      if (m_en) begin
        m_run++;
        m_frame = m_pp ? pp_seq[(m_run / PERIOD) % 6] : (m_run / PERIOD) % FRAMES;
      end
    end
    dx = x - m_ax;
    dy = y - m_ay;
    tx = (dx >= 0) ? dx / (1 << m_as) : -1;
    ty = (dy >= 0) ? dy / (1 << m_as) : -1;
    hit = dx >= 0 && dy >= 0 && tx < SPR_W && ty < SPR_H;
    addr = hit ? m_frame * SPR_W * SPR_H + ty * SPR_W + tx : 0;
    if (!blk) rgb = 0;
    else if (hit && rom_mem[addr] != 4'd0) rgb = pal(int'(rom_mem[addr]));
    else rgb = bg;
    push(cyc, 0, addr, $sformatf("addr(%0d,%0d)", x, y));
    push(cyc + 2, 1, rgb, $sformatf("rgb(%0d,%0d)", x, y));
    if (fs) push(cyc + 1, 2, m_frame, "frame_idx");
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b0; blank = 1'b1; pos_wr = 1'b0;
    anim_en = m_en; anim_pingpong = m_pp;
    sbq.delete();
    m_sx = 0; m_sy = 0; m_ss = 0; m_ax = 0; m_ay = 0; m_as = 0;
    m_frame = 0; m_run = 0; m_prev00 = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge vga_clk);
        #1;
      end
      DrawX = 10'($urandom_range(1, 639));
      DrawY = 10'($urandom_range(1, 479));
      push(cyc, 1, 0, "rst_rgb");
      push(cyc, 2, 0, "rst_frame");
      push(cyc, 0, 0, "rst_addr");
    end
    @(negedge vga_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
        step(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[0] = 4'd0;
    rom_mem[1] = 4'd5;
    m_en = 1'b0;
    m_pp = 1'b0;
    do_reset(3);

    // Placement at (100,50), scale 0
    step(200, 200, 1, 1, 100, 50, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(100, 50, 1, 0, 0, 0, 0);
    step(131, 81, 1, 0, 0, 0, 0);
    step(132, 50, 1, 0, 0, 0, 0);
    step(99, 50, 1, 0, 0, 0, 0);
    step(100, 49, 1, 0, 0, 0, 0);
    step(100, 50, 0, 0, 0, 0, 0);

    // Deferred commit, then scale 2 at the origin
    step(300, 300, 1, 1, 0, 0, 2);
    step(100, 50, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int x = 1; x <= 4; x++) step(x, 0, 1, 0, 0, 0, 0);
    step(127, 127, 1, 0, 0, 0, 0);
    step(128, 0, 1, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0, 0);

    // Write-through on the frame-start cycle
    step(5, 5, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 400, 300, 1);
    step(400, 300, 1, 0, 0, 0, 0);
    step(463, 363, 1, 0, 0, 0, 0);
    step(464, 300, 1, 0, 0, 0, 0);
    step(399, 300, 1, 0, 0, 0, 0);

    // Randomised pixels, writes and frame starts
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) step(0, 0, 1, 0, 0, 0, 0);
      else step(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)),
                 bit'($urandom_range(0, 4) != 0), r < 3,
                 int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                 int'($urandom_range(0, 3)));
    end

    // Loop animation, then hold
    m_en = 1'b1; m_pp = 1'b0;
    do_reset(2);
    run_frames(16);
    m_en = 1'b0;
    run_frames(4);

    // Ping-pong animation, then hold
    m_en = 1'b1; m_pp = 1'b1;
    do_reset(2);
    run_frames(16);
    m_en = 1'b0;
    run_frames(4);

    // Reset in the middle of a line, then refill
    step(20, 20, 1, 0, 0, 0, 0);
    step(21, 20, 1, 0, 0, 0, 0);
    do_reset(2);
    for (int x = 0; x < 8; x++) step(10 + x, 7, 1, 0, 0, 0, 0);

    begin
      int w;
      w = 0;
      while (sbq.size() > 0 && w < 10) begin
        @(posedge vga_clk);
        w++;
      end
      if (sbq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending=%0d expected=0", sbq.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
